// File: rtl/ct_f_spsram_arb.sv
// Two-requester round-robin arbiter in front of a single-port SRAM with 1-cycle read latency.
// Optional power-up clear of the whole array when CT_F_SPSRAM_ARB_INIT_CLR_EN is defined.
module ct_f_spsram_arb #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  r0_req,
  input  logic                  r0_wr,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [3:0]            r0_be,
  output logic                  r0_gnt,
  output logic                  r0_rvld,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_wr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic [3:0]            r1_be,
  output logic                  r1_gnt,
  output logic                  r1_rvld,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  init_done
);

  localparam int unsigned BE_WIDTH   = 4;
  localparam int unsigned LANE_WIDTH = DATA_WIDTH / BE_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t state;
  logic   rr;
  logic   rvld0;
  logic   rvld1;
`ifdef CT_F_SPSRAM_ARB_INIT_CLR_EN
  logic [ADDR_WIDTH-1:0] clr_addr;
`endif

  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_WIDTH-1:0]   sel_be;
  logic [DATA_WIDTH-1:0] wr_wen;
  logic                  access;
  logic                  clearing;

  // Round-robin grant; rr = 0 favours r0 on contention. Reset suppresses all grants.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!RST && state == RUN) begin
      if (r0_req && (!r1_req || !rr)) begin
        r0_gnt = 1'b1;
      end else if (r1_req) begin
        r1_gnt = 1'b1;
      end
    end
  end

  // Granted requester's command; r0 when nobody is granted so the mux has a default.
  always_comb begin
    sel_wr    = r1_gnt ? r1_wr    : r0_wr;
    sel_addr  = r1_gnt ? r1_addr  : r0_addr;
    sel_wdata = r1_gnt ? r1_wdata : r0_wdata;
    sel_be    = r1_gnt ? r1_be    : r0_be;
  end

  always_comb begin
    wr_wen = '1;
    for (int k = 0; k < BE_WIDTH; k++) begin
      wr_wen[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{~sel_be[k]}};
    end
  end

  // A write with no byte lanes enabled is accepted but never reaches the SRAM.
  assign access = (r0_gnt || r1_gnt) && (!sel_wr || (sel_be != '0));

`ifdef CT_F_SPSRAM_ARB_INIT_CLR_EN
  assign clearing = !RST && state == INIT;
`else
  assign clearing = 1'b0;
`endif

  always_comb begin
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_d    = '0;
    sram_wen  = '1;
    if (clearing) begin
`ifdef CT_F_SPSRAM_ARB_INIT_CLR_EN
      sram_a    = clr_addr;
`endif
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
    end else if (access) begin
      sram_a    = sel_addr;
      sram_cen  = 1'b0;
      sram_gwen = ~sel_wr;
      sram_d    = sel_wdata;
      sram_wen  = sel_wr ? wr_wen : '1;
    end
  end

  // FSM, round-robin pointer, read-valid pipeline and clear counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      rr    <= 1'b0;
      rvld0 <= 1'b0;
      rvld1 <= 1'b0;
`ifdef CT_F_SPSRAM_ARB_INIT_CLR_EN
      clr_addr <= '0;
`endif
    end else begin
      rvld0 <= r0_gnt && !r0_wr;
      rvld1 <= r1_gnt && !r1_wr;
      if (r0_gnt) begin
        rr <= 1'b1;
      end else if (r1_gnt) begin
        rr <= 1'b0;
      end
      case (state)
        INIT: begin
`ifdef CT_F_SPSRAM_ARB_INIT_CLR_EN
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (&clr_addr) begin
            state <= RUN;
          end
`else
          state <= RUN;
`endif
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Reset kills a read whose data would land in the reset cycle.
  assign r0_rvld   = rvld0 && !RST;
  assign r1_rvld   = rvld1 && !RST;
  assign r0_rdata  = r0_rvld ? sram_q : '0;
  assign r1_rdata  = r1_rvld ? sram_q : '0;
  assign init_done = (state == RUN);

endmodule

// File: tb/tb_ct_f_spsram_arb.sv
// Directed bench for ct_f_spsram_arb with a behavioural single-port SRAM attached.
module tb_ct_f_spsram_arb;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic          CLK;
  logic          RST;
  logic          r0_req, r0_wr, r0_gnt, r0_rvld;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic [3:0]    r0_be;
  logic          r1_req, r1_wr, r1_gnt, r1_rvld;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [3:0]    r1_be;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen, init_done;
  logic [DW-1:0] sram_d, sram_wen, sram_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  ct_f_spsram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_be(r0_be),
    .r0_gnt(r0_gnt), .r0_rvld(r0_rvld), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_be(r1_be),
    .r1_gnt(r1_gnt), .r1_rvld(r1_rvld), .r1_rdata(r1_rdata),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_d(sram_d),
    .sram_wen(sram_wen), .sram_q(sram_q), .init_done(init_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port SRAM: bit-masked write, registered read data.
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected summary before 1000000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic drive0(input logic req, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be);
    r0_req = req; r0_wr = wr; r0_addr = a; r0_wdata = d; r0_be = be;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] be);
    r1_req = req; r1_wr = wr; r1_addr = a; r1_wdata = d; r1_be = be;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_cen"},  32'(sram_cen),  32'd1);
    check({tag, "_gwen"}, 32'(sram_gwen), 32'd1);
    check({tag, "_wen"},  sram_wen,       32'hFFFF_FFFF);
    check({tag, "_a"},    32'(sram_a),    32'd0);
    check({tag, "_d"},    sram_d,         32'd0);
  endtask

  // Runs the INIT phase from the first post-reset cycle; returns at the start of the first RUN cycle.
  task automatic init_phase();
`ifdef CT_F_SPSRAM_ARB_INIT_CLR_EN
    for (int i = 0; i < (1 << AW); i++) begin
      sample();
      check("clear",
            32'({sram_cen, sram_gwen, |sram_wen, |sram_d, r0_gnt, r1_gnt, init_done, sram_a}),
            32'({7'b0, AW'(i)}));
      next_cycle();
    end
`else
    sample();
    check_idle_bus("init");
    check("init_gnt",     32'({r0_gnt, r1_gnt}), 32'd0);
    check("init_done_lo", 32'(init_done),        32'd0);
    next_cycle();
`endif
    check("init_done_hi", 32'(init_done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sram_q = '0;
    RST = 1'b1;
    drive0(1'b1, 1'b0, AW'(1), 32'h0, 4'hF);
    drive1(1'b1, 1'b0, AW'(2), 32'h0, 4'hF);
    repeat (3) @(posedge CLK);
    #1;

    // Reset state with both requests pending
    check_idle_bus("rst");
    check("rst_gnt",       32'({r0_gnt, r1_gnt}),   32'd0);
    check("rst_rvld",      32'({r0_rvld, r1_rvld}), 32'd0);
    check("rst_init_done", 32'(init_done),          32'd0);

`ifdef CT_F_SPSRAM_ARB_INIT_CLR_EN
    // Reset partway through the clear restarts it at address 0
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("pre_clr_a", 32'(sram_a), 32'(i));
      next_cycle();
    end
    RST = 1'b1;
    sample();
    check("midclr_rst_cen", 32'(sram_cen), 32'd1);
    next_cycle();
`endif
    RST = 1'b0;
    init_phase();

    // Continuous contention alternates r0, r1, r0, r1 with an access every cycle
    for (int k = 0; k < 4; k++) begin
      sample();
      check("rr_gnt0", 32'(r0_gnt),   32'((k % 2) == 0));
      check("rr_gnt1", 32'(r1_gnt),   32'((k % 2) == 1));
      check("rr_cen",  32'(sram_cen), 32'd0);
      check("rr_a",    32'(sram_a),   ((k % 2) == 0) ? 32'd1 : 32'd2);
      check("rr_rvld0", 32'(r0_rvld), 32'((k % 2) == 1));
      check("rr_rvld1", 32'(r1_rvld), 32'((k >= 2) && ((k % 2) == 0)));
      next_cycle();
    end
    drive0(1'b0, 1'b0, '0, '0, 4'h0);
    drive1(1'b0, 1'b0, '0, '0, 4'h0);
    sample();
    check("rr_tail_rvld", 32'({r0_rvld, r1_rvld}), 32'b01);
    check_idle_bus("idle");
    next_cycle();

    // r0 full write, then r1 reads it back
    drive0(1'b1, 1'b1, AW'(5), 32'hA5A5_A5A5, 4'b1111);
    sample();
    check("wr5_gnt",  32'({r0_gnt, r1_gnt}), 32'b10);
    check("wr5_cen",  32'(sram_cen),  32'd0);
    check("wr5_gwen", 32'(sram_gwen), 32'd0);
    check("wr5_wen",  sram_wen,       32'h0);
    check("wr5_a",    32'(sram_a),    32'd5);
    check("wr5_d",    sram_d,         32'hA5A5_A5A5);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0, 4'h0);
    drive1(1'b1, 1'b0, AW'(5), 32'h0, 4'h0);
    sample();
    check("rd5_gnt",  32'({r0_gnt, r1_gnt}), 32'b01);
    check("rd5_gwen", 32'(sram_gwen), 32'd1);
    check("rd5_wen",  sram_wen,       32'hFFFF_FFFF);
    next_cycle();

    // Read data returns while the other requester writes: no bubble
    drive1(1'b0, 1'b0, '0, '0, 4'h0);
    drive0(1'b1, 1'b1, AW'(16), 32'h0, 4'b1111);
    sample();
    check("rd5_rvld1",  32'(r1_rvld), 32'd1);
    check("rd5_rdata1", r1_rdata,     32'hA5A5_A5A5);
    check("rd5_rvld0",  32'(r0_rvld), 32'd0);
    check("rd5_rdata0", r0_rdata,     32'h0);
    check("b2b_gnt0",   32'(r0_gnt),  32'd1);
    check("b2b_cen",    32'(sram_cen), 32'd0);
    next_cycle();

    // Partial write over a cleared word
    drive0(1'b1, 1'b1, AW'(16), 32'h1122_3344, 4'b0101);
    sample();
    check("pw_gnt", 32'(r0_gnt), 32'd1);
    check("pw_wen", sram_wen,    32'hFF00_FF00);
    check("pw_rvld", 32'({r0_rvld, r1_rvld}), 32'd0);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0, 4'h0);
    drive1(1'b1, 1'b0, AW'(16), 32'h0, 4'h0);
    sample();
    check("pr_gnt", 32'({r0_gnt, r1_gnt}), 32'b01);
    next_cycle();
    drive1(1'b0, 1'b0, '0, '0, 4'h0);
    sample();
    check("pr_rvld",  32'(r1_rvld), 32'd1);
    check("pr_rdata", r1_rdata,     32'h0022_0044);
    next_cycle();

    // Write with no byte enables: granted, SRAM untouched
    drive1(1'b1, 1'b1, AW'(3), 32'hFFFF_FFFF, 4'b0000);
    sample();
    check("be0_gnt", 32'({r0_gnt, r1_gnt}), 32'b01);
    check_idle_bus("be0");
    next_cycle();
    drive1(1'b1, 1'b1, AW'(2047), 32'hDEAD_BEEF, 4'b1111);
    sample();
    check("be0_rvld", 32'({r0_rvld, r1_rvld}), 32'd0);
    check("top_wr_gnt", 32'(r1_gnt), 32'd1);
    next_cycle();

    // Read of the top address, then reset before its data returns
    drive1(1'b0, 1'b0, '0, '0, 4'h0);
    drive0(1'b1, 1'b0, AW'(2047), 32'h0, 4'h0);
    sample();
    check("top_rd_gnt", 32'({r0_gnt, r1_gnt}), 32'b10);
    check("top_rd_a",   32'(sram_a),    32'h7FF);
    check("top_rd_gwen", 32'(sram_gwen), 32'd1);
    next_cycle();
    RST = 1'b1;
    drive1(1'b1, 1'b0, AW'(2), 32'h0, 4'h0);
    sample();
    check("kill_rvld",  32'({r0_rvld, r1_rvld}), 32'd0);
    check("kill_rdata", r0_rdata,               32'h0);
    check("kill_gnt",   32'({r0_gnt, r1_gnt}),   32'd0);
    check_idle_bus("kill");
    next_cycle();
    RST = 1'b0;
    init_phase();

    // Pointer restarts at r0 after reset
    sample();
    check("post_gnt", 32'({r0_gnt, r1_gnt}), 32'b10);
    check("post_a",   32'(sram_a),           32'h7FF);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0, 4'h0);
    drive1(1'b0, 1'b0, '0, '0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
